inst_fetch: RTL

Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the program counter and fetches each 32-bit instruction as four little-endian bytes from the byte-wide memory controller, then presents `{pc, inst}` to the IF/ID register that feeds the decoder. Accepts stall requests from the pipeline controller and PC redirects from the execute stage (taken branch, JAL, JALR). An optional direct-mapped instruction cache serves repeated fetches without memory traffic.

---
 rtl/inst_fetch.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: RV32I instruction-fetch stage.
// Owns the PC, assembles each instruction from four little-endian bytes
// returned by the byte-wide memory controller, and presents {pc, inst} to
// the IF/ID register. Handles stalls and EX-stage redirects.
// Optional direct-mapped I-cache: define ICACHE_EN to enable it. Without the
// macro every fetch goes to memory and no cache storage exists.
module inst_fetch #(
    parameter int unsigned ICACHE_IDX_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_if,
    input  logic        jump_en,
    input  logic [31:0] jump_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_byte_valid,
    input  logic [7:0]  mem_byte,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ABORT = 2'd3
    } state_t;

    // The tag needs at least one bit above the index and byte offset.
    if (ICACHE_IDX_W == 0 || ICACHE_IDX_W > 29) begin : g_bad_idx_w
        $error("inst_fetch: ICACHE_IDX_W must be in 1..29");
    end

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  byte_cnt;
    logic [23:0] byte_buf;
    logic [31:0] pc_next;

    logic        lookup_hit;
    logic [31:0] lookup_data;

    // Sequential PC, used when an instruction is consumed.
    assign pc_next = pc + 32'd4;

`ifdef ICACHE_EN
    localparam int unsigned LINES = 1 << ICACHE_IDX_W;
    localparam int unsigned TAG_W = 32 - ICACHE_IDX_W - 2;

    logic [LINES-1:0]        line_valid;
    logic [TAG_W-1:0]        line_tag  [LINES];
    logic [31:0]             line_data [LINES];
    logic [31:0]             lookup_addr;
    logic [ICACHE_IDX_W-1:0] lookup_idx;
    logic [ICACHE_IDX_W-1:0] fill_idx;
    logic                    fill_en;
    logic                    unused_addr_bits;

    // Lookup address: current PC from IDLE, next sequential PC when consuming in HOLD.
    always_comb begin
        lookup_addr = (state == HOLD) ? pc_next : pc;
        lookup_idx  = lookup_addr[ICACHE_IDX_W+1:2];
        lookup_hit  = line_valid[lookup_idx]
                      && (line_tag[lookup_idx] == lookup_addr[31:ICACHE_IDX_W+2]);
        lookup_data = line_data[lookup_idx];
    end

    // A line is written only when a fetch completes without a redirect.
    assign fill_en  = rdy && !jump_en && (state == FETCH) && mem_byte_valid && (byte_cnt == 2'd3);
    assign fill_idx = pc[ICACHE_IDX_W+1:2];

    // Cache storage: valid bits cleared by reset, tag/data written on fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
        end else if (fill_en) begin
            line_valid[fill_idx] <= 1'b1;
            line_tag[fill_idx]   <= pc[31:ICACHE_IDX_W+2];
            line_data[fill_idx]  <= {mem_byte, byte_buf};
        end
    end

    assign unused_addr_bits = &{1'b0, lookup_addr[1:0]};
`else
    assign lookup_hit  = 1'b0;
    assign lookup_data = '0;
`endif

    logic unused_target_bits;
    assign unused_target_bits = &{1'b0, jump_target[1:0]};

    // Fetch FSM: PC, byte assembly and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            byte_cnt <= '0;
            byte_buf <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
        end else if (rdy) begin
            if (jump_en) begin
                // Redirect wins over everything else, including a completing fetch.
                pc       <= {jump_target[31:2], 2'b00};
                if_valid <= 1'b0;
                byte_cnt <= '0;
                mem_req  <= 1'b0;
                state    <= mem_req ? ABORT : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (lookup_hit) begin
                            if_inst  <= lookup_data;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= pc;
                            state    <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (mem_byte_valid) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            case (byte_cnt)
                                2'd0:    byte_buf[7:0]   <= mem_byte;
                                2'd1:    byte_buf[15:8]  <= mem_byte;
                                2'd2:    byte_buf[23:16] <= mem_byte;
                                default: begin
                                    if_inst  <= {mem_byte, byte_buf};
                                    if_pc    <= pc;
                                    if_valid <= 1'b1;
                                    mem_req  <= 1'b0;
                                    state    <= HOLD;
                                end
                            endcase
                        end
                    end
                    HOLD: begin
                        // Consumed: advance and start the next fetch in the same cycle.
                        if (!stall_if) begin
                            pc <= pc_next;
                            if (lookup_hit) begin
                                if_inst <= lookup_data;
                                if_pc   <= pc_next;
                            end else begin
                                if_valid <= 1'b0;
                                mem_req  <= 1'b1;
                                mem_addr <= pc_next;
                                state    <= FETCH;
                            end
                        end
                    end
                    ABORT: begin
                        // One quiet cycle so the controller drops the cancelled request.
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
